// File: rtl/tx_initiated_point_test_responder_pkg.sv
// Shared definitions for the D2C point-test sideband exchange: message codes,
// comparator control encodings, start-data fields and responder states.
package tx_initiated_point_test_responder_pkg;

  localparam int unsigned SB_MSG_W  = 4;
  localparam int unsigned SB_DATA_W = 16;
  localparam int unsigned CW_W      = 2;

  localparam logic [SB_MSG_W-1:0] MSG_NONE       = 4'b0000;
  localparam logic [SB_MSG_W-1:0] MSG_START_REQ  = 4'b0001;
  localparam logic [SB_MSG_W-1:0] MSG_START_RESP = 4'b0010;
  localparam logic [SB_MSG_W-1:0] MSG_CLR_REQ    = 4'b0011;
  localparam logic [SB_MSG_W-1:0] MSG_CLR_RESP   = 4'b0100;
  localparam logic [SB_MSG_W-1:0] MSG_RES_REQ    = 4'b0101;
  localparam logic [SB_MSG_W-1:0] MSG_RES_RESP   = 4'b0110;
  localparam logic [SB_MSG_W-1:0] MSG_END_REQ    = 4'b0111;
  localparam logic [SB_MSG_W-1:0] MSG_END_RESP   = 4'b1000;

  localparam logic [CW_W-1:0] CW_OFF     = 2'b00;
  localparam logic [CW_W-1:0] CW_CLEAR   = 2'b01;
  localparam logic [CW_W-1:0] CW_LFSR    = 2'b10;
  localparam logic [CW_W-1:0] CW_PERLANE = 2'b11;

  localparam int unsigned START_PATTERN_BIT = 0;
  localparam int unsigned START_BURST_BIT   = 4;
  localparam int unsigned START_MODE_BIT    = 5;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_WAIT_START    = 3'd1,
    ST_WAIT_CLEAR    = 3'd2,
    ST_COMPARE       = 3'd3,
    ST_WAIT_END      = 3'd4,
    ST_TEST_FINISHED = 3'd5
  } pt_state_e;

  typedef struct packed {
    logic compare_mode;
    logic burst;
    logic valtrain;
  } pt_cfg_t;

  // Extract the test configuration carried in START_REQ data.
  function automatic pt_cfg_t decode_start_data(input logic [SB_DATA_W-1:0] data);
    pt_cfg_t cfg;
    cfg.compare_mode = data[START_MODE_BIT];
    cfg.burst        = data[START_BURST_BIT];
    cfg.valtrain     = data[START_PATTERN_BIT];
    return cfg;
  endfunction

endpackage

// File: rtl/tx_initiated_point_test_responder_if.sv
// Sideband request/response bundle between the message mux and the responder.
interface tx_initiated_point_test_responder_if;
  import tx_initiated_point_test_responder_pkg::*;

  logic [SB_MSG_W-1:0]  i_sideband_message;
  logic [SB_DATA_W-1:0] i_sideband_data;
  logic                 i_sideband_message_valid;
  logic                 i_busy_negedge_detected;
  logic                 i_valid_rx;
  logic [SB_MSG_W-1:0]  o_sideband_message;
  logic                 o_valid_tx;
  logic [SB_DATA_W-1:0] o_sideband_data;
  logic                 o_data_valid;

  modport master (
    output i_sideband_message, i_sideband_data, i_sideband_message_valid,
           i_busy_negedge_detected, i_valid_rx,
    input  o_sideband_message, o_valid_tx, o_sideband_data, o_data_valid
  );

  modport slave (
    input  i_sideband_message, i_sideband_data, i_sideband_message_valid,
           i_busy_negedge_detected, i_valid_rx,
    output o_sideband_message, o_valid_tx, o_sideband_data, o_data_valid
  );

endinterface

// File: rtl/tx_initiated_point_test_responder_sb_resp_valid_ctrl.sv
// Response valid / data-valid flags: set when a response is issued, cleared once
// the sideband TX has sent it and the RX side is idle. Clear beats set.
module tx_initiated_point_test_responder_sb_resp_valid_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic set,
  input  logic set_data,
  input  logic busy_negedge,
  input  logic valid_rx,
  output logic valid_tx,
  output logic data_valid
);

  logic clr_c;
  assign clr_c = busy_negedge && !valid_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_tx   <= 1'b0;
      data_valid <= 1'b0;
    end else if (flush || clr_c) begin
      valid_tx   <= 1'b0;
      data_valid <= 1'b0;
    end else if (set) begin
      valid_tx   <= 1'b1;
      data_valid <= set_data;
    end
  end

endmodule

// File: rtl/tx_initiated_point_test_responder.sv
// Partner-side responder for the TX-initiated D2C point test: answers sideband
// requests, drives the local comparators and reports completion to the LTSM.
module tx_initiated_point_test_responder
  import tx_initiated_point_test_responder_pkg::*;
#(
  parameter int unsigned NUM_LANES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tx_initiated_point_test_responder_if.slave sb,
  input  logic                  i_en,
  input  logic                  i_lfsr_or_perlane,
  input  logic [NUM_LANES-1:0]  i_compare_result,
  input  logic                  i_val_result,
  output logic [CW_W-1:0]       o_comparator_cw,
  output logic                  o_val_compare_en,
  output logic                  o_test_ack_rx
);

  pt_state_e            state_q, state_d;
  pt_cfg_t              cfg_q, cfg_d;
  logic [SB_MSG_W-1:0]  msg_q, msg_d;
  logic [SB_DATA_W-1:0] data_q, data_d;
  logic [CW_W-1:0]      cw_q, cw_d;
  logic                 val_en_q, val_en_d;
  logic                 ack_q, ack_d;
  logic                 resp_set, resp_set_data, resp_flush;
  logic                 valid_tx_q, data_valid_q;
  logic                 req_c;
  logic                 unused_cfg_bits;

  assign req_c = sb.i_sideband_message_valid;

  // Burst and compare-mode fields are carried for the initiator side only.
  assign unused_cfg_bits = cfg_q.burst ^ cfg_q.compare_mode;

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    msg_d         = msg_q;
    data_d        = data_q;
    cw_d          = CW_OFF;
    val_en_d      = 1'b0;
    ack_d         = ack_q;
    resp_set      = 1'b0;
    resp_set_data = 1'b0;
    resp_flush    = 1'b0;

    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_WAIT_START;

        ST_WAIT_START: begin
          if (req_c && sb.i_sideband_message == MSG_START_REQ) begin
            cfg_d    = decode_start_data(sb.i_sideband_data);
            msg_d    = MSG_START_RESP;
            data_d   = '0;
            resp_set = 1'b1;
            state_d  = ST_WAIT_CLEAR;
          end
        end

        ST_WAIT_CLEAR: begin
          if (req_c && sb.i_sideband_message == MSG_CLR_REQ) begin
            msg_d    = MSG_CLR_RESP;
            data_d   = '0;
            resp_set = 1'b1;
            cw_d     = cfg_q.valtrain ? CW_OFF : CW_CLEAR;
            state_d  = ST_COMPARE;
          end
        end

        ST_COMPARE: begin
          if (req_c && sb.i_sideband_message == MSG_RES_REQ) begin
            msg_d         = MSG_RES_RESP;
            data_d        = cfg_q.valtrain ? SB_DATA_W'(i_val_result)
                                           : SB_DATA_W'(i_compare_result);
            resp_set      = 1'b1;
            resp_set_data = 1'b1;
            state_d       = ST_WAIT_END;
          end else if (cfg_q.valtrain) begin
            val_en_d = 1'b1;
          end else begin
            cw_d = i_lfsr_or_perlane ? CW_PERLANE : CW_LFSR;
          end
        end

        ST_WAIT_END: begin
          if (req_c && sb.i_sideband_message == MSG_END_REQ) begin
            msg_d    = MSG_END_RESP;
            data_d   = '0;
            resp_set = 1'b1;
            ack_d    = 1'b1;
            state_d  = ST_TEST_FINISHED;
          end
        end

        ST_TEST_FINISHED: state_d = ST_TEST_FINISHED;

        default: state_d = ST_IDLE;
      endcase
    end

    // Sitting in IDLE wipes every response, the ack and any stale config.
    if (state_q == ST_IDLE) begin
      msg_d      = MSG_NONE;
      data_d     = '0;
      ack_d      = 1'b0;
      cfg_d      = '0;
      resp_set   = 1'b0;
      resp_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      msg_q    <= MSG_NONE;
      data_q   <= '0;
      cw_q     <= CW_OFF;
      val_en_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      msg_q    <= msg_d;
      data_q   <= data_d;
      cw_q     <= cw_d;
      val_en_q <= val_en_d;
      ack_q    <= ack_d;
    end
  end

  tx_initiated_point_test_responder_sb_resp_valid_ctrl u_resp_valid (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (resp_flush),
    .set          (resp_set),
    .set_data     (resp_set_data),
    .busy_negedge (sb.i_busy_negedge_detected),
    .valid_rx     (sb.i_valid_rx),
    .valid_tx     (valid_tx_q),
    .data_valid   (data_valid_q)
  );

  assign sb.o_sideband_message = msg_q;
  assign sb.o_sideband_data    = data_q;
  assign sb.o_valid_tx         = valid_tx_q;
  assign sb.o_data_valid       = data_valid_q;
  assign o_comparator_cw       = cw_q;
  assign o_val_compare_en      = val_en_q;
  assign o_test_ack_rx         = ack_q;

endmodule

// File: doc/tx_initiated_point_test_responder.md
# tx_initiated_point_test_responder

Partner-side responder for the TX-initiated D2C point test. It answers the initiator's sideband requests (start, LFSR clear, result, end) and drives the local pattern comparators. It returns the per-lane compare result in the result response and signals test completion to the LTSM. It sits in the RX D2C point-test path, between the sideband message mux and the mainband/valtrain comparators.

## Interface
Parameters:
- NUM_LANES, 16, mainband lanes reported in the result response (≤16)

Ports:
- clk  in  1  block clock
- rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  LTSM enable; low aborts to IDLE
- i_lfsr_or_perlane  in  1  0 = LFSR compare, 1 = per-lane-ID compare
- i_sideband_message  in  4  decoded incoming message
- i_sideband_data  in  16  incoming message data
- i_sideband_message_valid  in  1  incoming message strobe
- i_busy_negedge_detected  in  1  sideband TX busy falling edge (message sent)
- i_valid_rx  in  1  sideband RX currently holding a valid message
- i_compare_result  in  NUM_LANES  per-lane pass mask from mainband comparator
- i_val_result  in  1  valtrain comparator pass
- o_sideband_message  out  4  response code
- o_valid_tx  out  1  response valid to sideband mux
- o_sideband_data  out  16  response data
- o_data_valid  out  1  response carries data
- o_comparator_cw  out  2  00 off, 01 clear, 10 LFSR compare, 11 per-lane compare
- o_val_compare_en  out  1  valtrain comparator enable
- o_test_ack_rx  out  1  test complete to LTSM

## Operation
Message codes (shared package): 0001 START_REQ, 0010 START_RESP, 0011 CLR_REQ, 0100 CLR_RESP, 0101 RES_REQ, 0110 RES_RESP, 0111 END_REQ, 1000 END_RESP.

FSM states: IDLE, WAIT_START, WAIT_CLEAR, COMPARE, WAIT_END, TEST_FINISHED.
- IDLE → WAIT_START when i_en.
- WAIT_START: on valid 0001, latch start data (bit0 pattern: 0 mainband, 1 valtrain; bit4 burst; bit5 compare mode) into r_cfg, send 0010, → WAIT_CLEAR.
- WAIT_CLEAR: on valid 0011, send 0100, pulse o_comparator_cw=01 for one cycle (mainband only), → COMPARE.
- COMPARE: comparator active. Mainband: cw=10 (i_lfsr_or_perlane=0) or 11. Valtrain: o_val_compare_en=1, cw=00. On valid 0101: comparators off; latch result; send 0110 with o_sideband_data = mainband ? zero-extended i_compare_result : {15'h0, i_val_result}; o_data_valid=1. Then → WAIT_END.
- WAIT_END: on valid 0111, send 1000, set o_test_ack_rx, → TEST_FINISHED.
- TEST_FINISHED: hold until i_en low.
- Any state with i_en low → IDLE. Comparators off. Ack cleared.
- Messages not matching the state's expected code are ignored. This includes repeats of already-answered requests.
- START_RESP, CLR_RESP and END_RESP carry o_sideband_data=0 and o_data_valid=0.

## Timing
- Reset values: all outputs 0, state IDLE, r_cfg 0.
- Request accepted in cycle N (valid and matching code) → o_sideband_message, o_sideband_data and o_valid_tx updated at N+1. o_data_valid rises at N+1 for RES_RESP only.
- Comparator control changes take effect at N+1. The clear pulse is high exactly at N+1. The compare code starts at N+2.
- o_valid_tx and o_data_valid hold until i_busy_negedge_detected && ~i_valid_rx, then clear next cycle. The clear wins over a same-cycle set.
- o_sideband_message holds its last value until the next response. It returns to 0000 in IDLE.
- The result is sampled in the cycle the RES_REQ is accepted. Comparator output after that point is ignored.
- i_en low mid-test: state → IDLE at next edge; the following edge clears all outputs, including a pending o_valid_tx.
- Re-enable after abort restarts from WAIT_START with no stale config.

## Structure
- Shared package: message-code localparams, comparator cw encodings, start-data bit positions. Reused by the TX initiator.
- The FSM plus output registers form one module.
- A natural sub-module is sb_resp_valid_ctrl, which owns the o_valid_tx/o_data_valid set/clear handshake. The TX side can reuse it.

## Test plan
- Full mainband LFSR test: 0001(data 0)→0010; 0011→0100 plus a one-cycle cw=01 then cw=10; 0101 with i_compare_result=16'hFFF0 → 0110, data FFF0, o_data_valid=1; 0111→1000, ack=1.
- Valtrain test: start data 16'h0011 → cw stays 00 and val_compare_en=1 in COMPARE; i_val_result=1 → RES_RESP data 0x0001.
- Out-of-order: 0101 sent in WAIT_CLEAR → no response, state unchanged; a later 0011 is answered normally.
- Handshake: busy negedge with i_valid_rx=1 → o_valid_tx stays 1; the next busy negedge with i_valid_rx=0 → 0 one cycle later.
- Abort: i_en dropped in COMPARE → comparators off and outputs 0 within 2 cycles; re-enable then 0001 → 0010.
- Reset asserted asynchronously mid-RES_RESP → all outputs 0 immediately, IDLE after release.
